// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD frame feeder.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_ADDR1 = 3'd1,
        ST_LINE1 = 3'd2,
        ST_ADDR2 = 3'd3,
        ST_LINE2 = 3'd4
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_LINE1  = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2  = 8'hC0;
    localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;

    localparam int LCD_COLS  = 16;
    localparam int LCD_ROWS  = 2;
    localparam int LCD_CELLS = LCD_COLS * LCD_ROWS;

    // Row-major cell address: row 0 at 0..15, row 1 at 16..31.
    function automatic logic [4:0] lcd_cell_addr(input logic row, input logic [3:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// 32x8 character frame buffer: synchronous write, asynchronous read,
// synchronous active-low reset to all spaces.
module lcd_frame_ram
    import lcd_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       WR_EN,
    input  logic [4:0] WR_ADDR,
    input  logic [7:0] WR_CHAR,
    input  logic [4:0] RD_ADDR,
    output logic [7:0] RD_CHAR
);

    logic [7:0] mem_r [LCD_CELLS];

    // Cell storage with reset to blank screen.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            for (int i = 0; i < LCD_CELLS; i++) begin
                mem_r[i] <= LCD_CHAR_SPACE;
            end
        end else if (WR_EN) begin
            mem_r[WR_ADDR] <= WR_CHAR;
        end
    end

    assign RD_CHAR = mem_r[RD_ADDR];

endmodule

// File: rtl/lcd_frame_feeder.sv
// Streams a 2x16 character frame as LCD command/data beats over valid/ready.
// Optional build macro LCD_FEED_DIRTY_EN: only refresh when the buffer changed.
module lcd_frame_feeder
    import lcd_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 400,
    parameter logic [7:0]  LINE1_CMD      = LCD_CMD_LINE1,
    parameter logic [7:0]  LINE2_CMD      = LCD_CMD_LINE2
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       WR_EN,
    input  logic [4:0] WR_ADDR,
    input  logic [7:0] WR_CHAR,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       OUT_RS,
    output logic [7:0] OUT_DATA,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    localparam int unsigned         TIMER_W  = $clog2(REFRESH_CYCLES + 1);
    localparam logic [TIMER_W-1:0]  TIMER_TC = TIMER_W'(REFRESH_CYCLES - 1);
    localparam logic [3:0]          LAST_COL = 4'(LCD_COLS - 1);

    lcd_state_t         state_r, state_nxt_s;
    logic [3:0]         idx_r, idx_nxt_s;
    logic [TIMER_W-1:0] timer_r;
    logic               out_valid_r, out_rs_r, busy_r, frame_done_r;
    logic [7:0]         out_data_r;
    logic               valid_nxt_s, rs_nxt_s;
    logic [7:0]         data_nxt_s;
    logic               xfer_s, tc_s, start_s, last_s, load_s;
    logic [4:0]         rd_addr_s;
    logic [7:0]         rd_char_s;

    assign xfer_s = out_valid_r & OUT_READY;
    assign tc_s   = (state_r == ST_WAIT) && (timer_r == TIMER_TC);
    assign last_s = xfer_s && (state_r == ST_LINE2) && (idx_r == LAST_COL);
    assign load_s = start_s | xfer_s;

`ifdef LCD_FEED_DIRTY_EN
    logic dirty_r;

    // Change tracking; a write in the start cycle keeps the next frame pending.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            dirty_r <= 1'b1;
        end else if (WR_EN) begin
            dirty_r <= 1'b1;
        end else if (start_s) begin
            dirty_r <= 1'b0;
        end else begin
            dirty_r <= dirty_r;
        end
    end

    assign start_s = tc_s & dirty_r;
`else
    assign start_s = tc_s;
`endif

    lcd_frame_ram u_ram (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .WR_EN   (WR_EN),
        .WR_ADDR (WR_ADDR),
        .WR_CHAR (WR_CHAR),
        .RD_ADDR (rd_addr_s),
        .RD_CHAR (rd_char_s)
    );

    // FSM state and character index register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_r <= ST_WAIT;
            idx_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state: advance only on accepted beats, index wraps at line change.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_WAIT: begin
                if (start_s) begin
                    state_nxt_s = ST_ADDR1;
                    idx_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ADDR1: begin
                if (xfer_s) begin
                    state_nxt_s = ST_LINE1;
                end else begin
                    state_nxt_s = ST_ADDR1;
                end
            end
            ST_LINE1: begin
                if (xfer_s && (idx_r == LAST_COL)) begin
                    state_nxt_s = ST_ADDR2;
                    idx_nxt_s   = 4'd0;
                end else if (xfer_s) begin
                    idx_nxt_s   = idx_r + 4'd1;
                end else begin
                    idx_nxt_s   = idx_r;
                end
            end
            ST_ADDR2: begin
                if (xfer_s) begin
                    state_nxt_s = ST_LINE2;
                end else begin
                    state_nxt_s = ST_ADDR2;
                end
            end
            ST_LINE2: begin
                if (xfer_s && (idx_r == LAST_COL)) begin
                    state_nxt_s = ST_WAIT;
                    idx_nxt_s   = 4'd0;
                end else if (xfer_s) begin
                    idx_nxt_s   = idx_r + 4'd1;
                end else begin
                    idx_nxt_s   = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT;
                idx_nxt_s   = 4'd0;
            end
        endcase
    end

    // Output: load the beat for the upcoming state, otherwise hold it stable.
    always_comb begin
        rd_addr_s   = lcd_cell_addr(state_nxt_s == ST_LINE2, idx_nxt_s);
        valid_nxt_s = out_valid_r;
        rs_nxt_s    = out_rs_r;
        data_nxt_s  = out_data_r;
        if (load_s) begin
            case (state_nxt_s)
                ST_ADDR1: begin
                    valid_nxt_s = 1'b1;
                    rs_nxt_s    = 1'b0;
                    data_nxt_s  = LINE1_CMD;
                end
                ST_LINE1, ST_LINE2: begin
                    valid_nxt_s = 1'b1;
                    rs_nxt_s    = 1'b1;
                    data_nxt_s  = rd_char_s;
                end
                ST_ADDR2: begin
                    valid_nxt_s = 1'b1;
                    rs_nxt_s    = 1'b0;
                    data_nxt_s  = LINE2_CMD;
                end
                default: begin
                    valid_nxt_s = 1'b0;
                end
            endcase
        end else begin
            valid_nxt_s = out_valid_r;
        end
    end

    // Registered outputs and refresh timer.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            out_valid_r  <= 1'b0;
            out_rs_r     <= 1'b0;
            out_data_r   <= 8'h00;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            timer_r      <= '0;
        end else begin
            out_valid_r  <= valid_nxt_s;
            out_rs_r     <= rs_nxt_s;
            out_data_r   <= data_nxt_s;
            busy_r       <= (state_nxt_s != ST_WAIT);
            frame_done_r <= last_s;
            if ((state_r == ST_WAIT) && !tc_s) begin
                timer_r <= timer_r + TIMER_W'(1);
            end else begin
                timer_r <= '0;
            end
        end
    end

    assign OUT_VALID  = out_valid_r;
    assign OUT_RS     = out_rs_r;
    assign OUT_DATA   = out_data_r;
    assign BUSY       = busy_r;
    assign FRAME_DONE = frame_done_r;

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// Randomized self-checking bench for lcd_frame_feeder against a frame-position model.
module tb_lcd_frame_feeder;

    localparam int R = 4;

    logic       CLK = 1'b0;
    logic       RESETN, WR_EN, OUT_READY;
    logic [4:0] WR_ADDR;
    logic [7:0] WR_CHAR;
    logic       OUT_VALID, OUT_RS, BUSY, FRAME_DONE;
    logic [7:0] OUT_DATA;

    always #5 CLK = ~CLK;

    lcd_frame_feeder #(.REFRESH_CYCLES(R)) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_CHAR    (WR_CHAR),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_RS     (OUT_RS),
        .OUT_DATA   (OUT_DATA),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    int assert_cnt = 0;
    int fail_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: beat position within the frame (-1 = waiting), timer, buffer image.
    logic [7:0] m_buf [32];
    int         m_pos, m_timer, cyc;
    logic       m_valid, m_rs, m_done, m_busy, m_chk_data;
    logic [7:0] m_data;
    bit         m_dirty;
    logic [8:0] beats [$];
    int         done_cyc [$];

    function automatic logic [8:0] beat_of(input int pos);
        if (pos == 0)       return {1'b0, 8'h80};
        else if (pos <= 16) return {1'b1, m_buf[pos-1]};
        else if (pos == 17) return {1'b0, 8'hC0};
        else                return {1'b1, m_buf[pos-2]};
    endfunction

    task automatic model_edge();
        bit go;
        bit xfer;
        if (!RESETN) begin
            for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
            m_pos = -1; m_timer = 0; m_valid = 1'b0; m_rs = 1'b0; m_data = 8'h00;
            m_done = 1'b0; m_dirty = 1'b1; m_chk_data = 1'b1;
        end else begin
            xfer       = m_valid && OUT_READY;
            m_done     = xfer && (m_pos == 33);
            m_chk_data = 1'b0;
            if (m_pos < 0) begin
                if (m_timer == R - 1) begin
                    m_timer = 0;
`ifdef LCD_FEED_DIRTY_EN
                    go = m_dirty;
`else
                    go = 1'b1;
`endif
                    if (go) begin
                        m_pos = 0; m_valid = 1'b1; {m_rs, m_data} = beat_of(0); m_dirty = 1'b0;
                    end
                end else begin
                    m_timer++;
                end
            end else if (xfer) begin
                if (m_pos == 33) begin
                    m_pos = -1; m_valid = 1'b0;
                end else begin
                    m_pos++; {m_rs, m_data} = beat_of(m_pos);
                end
            end
            if (WR_EN) begin
                m_buf[WR_ADDR] = WR_CHAR; m_dirty = 1'b1;
            end
        end
        m_busy = (m_pos >= 0);
    endtask

    task automatic step();
        if (RESETN && OUT_VALID && OUT_READY) beats.push_back({OUT_RS, OUT_DATA});
        model_edge();
        @(posedge CLK);
        #1;
        cyc++;
        check_eq("valid", OUT_VALID, m_valid);
        check_eq("busy", BUSY, m_busy);
        check_eq("frame_done", FRAME_DONE, m_done);
        if (m_valid || m_chk_data) begin
            check_eq("rs", OUT_RS, m_rs);
            check_eq("data", OUT_DATA, m_data);
        end
        if (FRAME_DONE) done_cyc.push_back(cyc);
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] c);
        WR_EN = 1'b1; WR_ADDR = a; WR_CHAR = c;
        step();
        WR_EN = 1'b0;
    endtask

    task automatic ensure_wait();
        for (int i = 0; i < 200 && m_pos >= 0; i++) step();
    endtask

    task automatic wait_frame_end();
        for (int i = 0; i < 300; i++) begin
            step();
            if (m_done) break;
        end
        check_eq("frame_end", FRAME_DONE, 1'b1);
    endtask

    task automatic run_until_pos(input int p);
        for (int i = 0; i < 200 && m_pos != p; i++) step();
    endtask

    initial begin
        int ns;
        RESETN = 1'b0; WR_EN = 1'b0; WR_ADDR = 5'd0; WR_CHAR = 8'h00; OUT_READY = 1'b1;
        cyc = 0;
        step();
        step();
        RESETN = 1'b1;

        // Blank frames with ready held high.
        beats.delete(); done_cyc.delete();
        for (int i = 0; i < 2 * (R + 34) + 2; i++) step();
        check_eq("blank_count", beats.size() >= 34, 1'b1);
        check_eq("blank_beat0", beats[0], 9'h080);
        check_eq("blank_beat17", beats[17], 9'h0C0);
        ns = 0;
        for (int i = 1; i < 34; i++) if (i != 17 && beats[i] != 9'h120) ns++;
        check_eq("blank_chars", ns, 0);
`ifndef LCD_FEED_DIRTY_EN
        check_eq("done_pulses", done_cyc.size(), 2);
        check_eq("frame_period", done_cyc[1] - done_cyc[0], R + 34);
`endif

        // Two characters placed on different lines.
        ensure_wait();
        beats.delete();
        poke(5'd0, 8'h48);
        poke(5'd17, 8'h49);
        wait_frame_end();
        check_eq("hello_beat2", beats[1], 9'h148);
        check_eq("hello_beat20", beats[19], 9'h149);
        check_eq("hello_beat3", beats[2], 9'h120);

        // Ready toggling every cycle.
        ensure_wait();
        poke(5'd0, 8'h48);
        beats.delete();
        for (int i = 0; i < 400 && !m_done; i++) begin
            OUT_READY = ~OUT_READY;
            step();
        end
        OUT_READY = 1'b1;
        check_eq("toggle_count", beats.size(), 34);
        check_eq("toggle_beat2", beats[1], 9'h148);
        check_eq("toggle_beat20", beats[19], 9'h149);

        // Write landing in the same cycle its cell is loaded.
        ensure_wait();
        poke(5'd0, 8'h48);
        beats.delete();
        run_until_pos(5);
        poke(5'd5, 8'h41);
        wait_frame_end();
        check_eq("rbw_old", beats[6], 9'h120);
        beats.delete();
        wait_frame_end();
        check_eq("rbw_new", beats[6], 9'h141);

        // Reset during line 1.
        ensure_wait();
        poke(5'd1, 8'h55);
        run_until_pos(8);
        RESETN = 1'b0;
        step();
        check_eq("rst_valid", OUT_VALID, 1'b0);
        check_eq("rst_busy", BUSY, 1'b0);
        RESETN = 1'b1;
        beats.delete();
        wait_frame_end();
        check_eq("rst_count", beats.size(), 34);
        ns = 0;
        for (int i = 0; i < 34; i++) if (beats[i][8] && beats[i][7:0] != 8'h20) ns++;
        check_eq("rst_spaces", ns, 0);

        // Random writes and backpressure.
        for (int i = 0; i < 1500; i++) begin
            OUT_READY = ($urandom_range(0, 3) != 0);
            WR_EN     = ($urandom_range(0, 7) == 0);
            WR_ADDR   = 5'($urandom_range(0, 31));
            WR_CHAR   = 8'($urandom_range(0, 255));
            step();
        end
        WR_EN = 1'b0; OUT_READY = 1'b1;

`ifdef LCD_FEED_DIRTY_EN
        for (int i = 0; i < 2 * (R + 34) + R; i++) step();
        beats.delete();
        for (int i = 0; i < 3 * R; i++) step();
        check_eq("dirty_idle", beats.size(), 0);
        poke(5'd3, 8'h5A);
        beats.delete();
        for (int i = 0; i < 2 * R + 36; i++) step();
        check_eq("dirty_once", beats.size(), 34);
        check_eq("dirty_char", beats[4], 9'h15A);
`else
        ensure_wait();
        for (int i = 0; i < R + 2; i++) step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
